// File: rtl/pixel_frame_buffer.sv
// Banked pixel framebuffer with a registered read port for scan-out and a
// clear engine that fills every bank in parallel, one pixel per bank per cycle.
module pixel_frame_buffer #(
  parameter int unsigned DATA_SIZE   = 4,
  parameter int unsigned ROWS        = 480,
  parameter int unsigned COLUMNS     = 640,
  parameter int unsigned BANK_ROWS   = 32,
  parameter int unsigned ROW_BITS    = 9,
  parameter int unsigned COLUMN_BITS = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   WRITE,
  input  logic [ROW_BITS-1:0]    ROW,
  input  logic [COLUMN_BITS-1:0] COLUMN,
  input  logic [DATA_SIZE-1:0]   IN_DATA,
  input  logic [ROW_BITS-1:0]    READ_ROW,
  input  logic [COLUMN_BITS-1:0] READ_COLUMN,
  output logic [DATA_SIZE-1:0]   OUT_DATA,
  input  logic                   CLEAR,
  input  logic [DATA_SIZE-1:0]   CLEAR_DATA,
  output logic                   BUSY,
  output logic                   WRITE_ERROR
);

  localparam int unsigned NB     = (ROWS + BANK_ROWS - 1) / BANK_ROWS;
  localparam int unsigned LR_W   = $clog2(BANK_ROWS);
  localparam int unsigned BK_W   = ROW_BITS - LR_W;
  localparam int unsigned DEPTH  = BANK_ROWS * COLUMNS;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [LR_W-1:0]        row_q, row_d;
  logic [COLUMN_BITS-1:0] col_q, col_d;
  logic [DATA_SIZE-1:0]   color_q, color_d;
  logic                   busy_q;
  logic                   err_q;
  logic [DATA_SIZE-1:0]   out_q, out_d;

  logic                   wr_ok_c;
  logic                   rd_ok_c;
  logic                   fill_we_c;
  logic [BK_W-1:0]        wr_bank_c, rd_bank_c;
  logic [ADDR_W-1:0]      wr_addr_c, rd_addr_c, fill_addr_c;
  logic [DATA_SIZE-1:0]   bank_rd [NB];

  // Linear address of (local row, column) inside one bank.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [LR_W-1:0] lr,
                                                  input logic [COLUMN_BITS-1:0] col);
    return ADDR_W'(lr) * ADDR_W'(COLUMNS) + ADDR_W'(col);
  endfunction

  // Address decode and port qualification.
  always_comb begin
    wr_ok_c     = WRITE && (state_q == S_IDLE) &&
                  (32'(ROW) < ROWS) && (32'(COLUMN) < COLUMNS);
    rd_ok_c     = (32'(READ_ROW) < ROWS) && (32'(READ_COLUMN) < COLUMNS);
    fill_we_c   = (state_q == S_FILL) && !RST;
    wr_bank_c   = ROW[ROW_BITS-1:LR_W];
    rd_bank_c   = READ_ROW[ROW_BITS-1:LR_W];
    wr_addr_c   = bank_addr(ROW[LR_W-1:0], COLUMN);
    rd_addr_c   = bank_addr(READ_ROW[LR_W-1:0], READ_COLUMN);
    fill_addr_c = bank_addr(row_q, col_q);
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Bank storage: fill writes every bank at once, CPU writes hit one bank.
    always_ff @(posedge CLK) begin
      if (fill_we_c) begin
        mem[fill_addr_c] <= color_q;
      end else if (wr_ok_c && !RST && (wr_bank_c == BK_W'(b))) begin
        mem[wr_addr_c] <= IN_DATA;
      end
    end

    assign bank_rd[b] = mem[rd_addr_c];
  end

  // Read mux; memory is sampled before this edge's write lands (read-first).
  always_comb begin
    out_d = '0;
    if (rd_ok_c) begin
      out_d = bank_rd[rd_bank_c];
    end
  end

  // Clear engine next-state: walks local rows x columns once.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    color_d = color_q;
    case (state_q)
      S_IDLE: begin
        if (CLEAR) begin
          state_d = S_FILL;
          row_d   = '0;
          col_d   = '0;
          color_d = CLEAR_DATA;
        end
      end
      S_FILL: begin
        if (32'(col_q) == COLUMNS - 1) begin
          col_d = '0;
          if (32'(row_q) == BANK_ROWS - 1) begin
            state_d = S_IDLE;
          end else begin
            row_d = row_q + LR_W'(1);
          end
        end else begin
          col_d = col_q + COLUMN_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      color_q <= color_d;
      busy_q  <= (state_d == S_FILL);
      err_q   <= WRITE && !wr_ok_c;
      out_q   <= out_d;
    end
  end

  assign OUT_DATA    = out_q;
  assign BUSY        = busy_q;
  assign WRITE_ERROR = err_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer at default geometry.
module tb_pixel_frame_buffer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WRITE;
  logic [8:0] ROW;
  logic [9:0] COLUMN;
  logic [3:0] IN_DATA;
  logic [8:0] READ_ROW;
  logic [9:0] READ_COLUMN;
  logic [3:0] OUT_DATA;
  logic       CLEAR;
  logic [3:0] CLEAR_DATA;
  logic       BUSY;
  logic       WRITE_ERROR;

  int checks = 0;
  int errors = 0;
  int n;

  pixel_frame_buffer dut (
    .CLK        (CLK),
    .RST        (RST),
    .WRITE      (WRITE),
    .ROW        (ROW),
    .COLUMN     (COLUMN),
    .IN_DATA    (IN_DATA),
    .READ_ROW   (READ_ROW),
    .READ_COLUMN(READ_COLUMN),
    .OUT_DATA   (OUT_DATA),
    .CLEAR      (CLEAR),
    .CLEAR_DATA (CLEAR_DATA),
    .BUSY       (BUSY),
    .WRITE_ERROR(WRITE_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int r, input int c, input logic [3:0] d, input logic exp_err,
                    input string tag);
    WRITE = 1'b1; ROW = 9'(r); COLUMN = 10'(c); IN_DATA = d;
    step();
    WRITE = 1'b0;
    chk(tag, 32'(WRITE_ERROR), 32'(exp_err));
  endtask

  task automatic rd(input int r, input int c, input logic [3:0] exp, input string tag);
    READ_ROW = 9'(r); READ_COLUMN = 10'(c);
    step();
    chk(tag, 32'(OUT_DATA), 32'(exp));
  endtask

  initial begin
    RST = 1'b1; WRITE = 1'b0; ROW = '0; COLUMN = '0; IN_DATA = '0;
    READ_ROW = '0; READ_COLUMN = '0; CLEAR = 1'b0; CLEAR_DATA = '0;
    #1;
    step(); step();
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_out", 32'(OUT_DATA), 0);
    chk("rst_err", 32'(WRITE_ERROR), 0);
    RST = 1'b0;
    step();

    // Basic write then read
    wr(100, 200, 4'hA, 1'b0, "wr_100_200_err");
    rd(100, 200, 4'hA, "rd_100_200");

    // Bank boundary and far corner
    wr(31, 0, 4'h3, 1'b0, "wr_31_0_err");
    wr(32, 0, 4'h5, 1'b0, "wr_32_0_err");
    wr(479, 639, 4'hF, 1'b0, "wr_479_639_err");
    rd(31, 0, 4'h3, "rd_31_0");
    rd(32, 0, 4'h5, "rd_32_0");
    rd(479, 639, 4'hF, "rd_479_639");

    // Out of range writes; (0,0) and (1,0) are the likely alias targets
    wr(0, 0, 4'h4, 1'b0, "wr_0_0_err");
    wr(1, 0, 4'h8, 1'b0, "wr_1_0_err");
    wr(480, 0, 4'h6, 1'b1, "oor_row_err");
    step();
    chk("oor_err_pulse", 32'(WRITE_ERROR), 0);
    wr(0, 640, 4'h6, 1'b1, "oor_col_err");
    rd(480, 0, 4'h0, "rd_oor_row");
    rd(0, 700, 4'h0, "rd_oor_col");
    rd(0, 0, 4'h4, "rd_0_0_kept");
    rd(1, 0, 4'h8, "rd_1_0_kept");
    chk("err_clear", 32'(WRITE_ERROR), 0);

    // Read-first collision
    wr(10, 10, 4'h1, 1'b0, "wr_10_10_err");
    WRITE = 1'b1; ROW = 9'd10; COLUMN = 10'd10; IN_DATA = 4'h2;
    READ_ROW = 9'd10; READ_COLUMN = 10'd10;
    step();
    WRITE = 1'b0;
    chk("collide_old", 32'(OUT_DATA), 32'h1);
    step();
    chk("collide_new", 32'(OUT_DATA), 32'h2);

    // Full clear with 7; mid-fill write and re-CLEAR must be ignored
    CLEAR = 1'b1; CLEAR_DATA = 4'h7;
    step();
    CLEAR = 1'b0; CLEAR_DATA = 4'h0;
    n = 0;
    while (BUSY === 1'b1 && n < 30000) begin
      if (n == 5000) begin
        WRITE = 1'b1; ROW = 9'd66; COLUMN = 10'd5; IN_DATA = 4'hE;
        CLEAR = 1'b1; CLEAR_DATA = 4'h3;
      end
      step();
      n++;
      if (n == 5001) begin
        chk("fill_wr_err", 32'(WRITE_ERROR), 1);
        WRITE = 1'b0; CLEAR = 1'b0;
      end
    end
    chk("busy_cycles", 32'(n), 32'd20480);
    chk("busy_done", 32'(BUSY), 0);
    rd(0, 0, 4'h7, "clr_0_0");
    rd(255, 317, 4'h7, "clr_255_317");
    rd(479, 639, 4'h7, "clr_479_639");
    rd(66, 5, 4'h7, "clr_66_5");
    rd(10, 10, 4'h7, "clr_10_10");

    // Reset after 1000 fill cycles of colour C
    wr(31, 639, 4'h9, 1'b0, "wr_31_639_err");
    CLEAR = 1'b1; CLEAR_DATA = 4'hC;
    step();
    CLEAR = 1'b0;
    repeat (1000) step();
    RST = 1'b1;
    step();
    chk("abort_busy", 32'(BUSY), 0);
    RST = 1'b0;
    rd(0, 0, 4'hC, "abort_0_0");
    rd(33, 0, 4'hC, "abort_33_0");
    rd(1, 400, 4'h7, "abort_1_400");
    rd(31, 639, 4'h9, "abort_31_639");
    chk("abort_idle", 32'(BUSY), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
Parametrised banked pixel framebuffer, successor to the fixed 480x635, 4-bit, 15-bank pixel array. Geometry, pixel width and bank height are parameters. Separate registered read port for the display scanner. Hardware clear engine fills the whole frame with one colour, writing all banks in parallel. Sits between the CPU-side pixel writer and the VGA scan-out logic.

Parameters:
DATA_SIZE, 4, bits per pixel
ROWS, 480, visible rows
COLUMNS, 640, visible columns
BANK_ROWS, 32, rows per bank (power of two); bank count NB = ceil(ROWS/BANK_ROWS) = 15
ROW_BITS, 9, width of row addresses
COLUMN_BITS, 10, width of column addresses

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
WRITE  in  1  write request for IN_DATA at ROW/COLUMN
ROW  in  ROW_BITS  write row
COLUMN  in  COLUMN_BITS  write column
IN_DATA  in  DATA_SIZE  write pixel
READ_ROW  in  ROW_BITS  read row
READ_COLUMN  in  COLUMN_BITS  read column
OUT_DATA  out  DATA_SIZE  registered read pixel
CLEAR  in  1  start clear-screen
CLEAR_DATA  in  DATA_SIZE  fill colour, sampled with CLEAR
BUSY  out  1  clear engine active
WRITE_ERROR  out  1  one-cycle pulse: a WRITE was dropped

Behaviour:
- Clock and reset: single clock CLK; RST synchronous, active-high.
- Addressing: bank = row / BANK_ROWS (row[ROW_BITS-1:log2(BANK_ROWS)]). Local row = row mod BANK_ROWS. Each bank holds BANK_ROWS x COLUMNS pixels.
- Reset: FSM -> IDLE; row/column counters = 0; BUSY=0; OUT_DATA=0; WRITE_ERROR=0. Memory contents are not reset. RST during a clear aborts it; pixels already written keep the fill colour.
- Write port:
  - Accepted when WRITE=1, BUSY=0, ROW<ROWS and COLUMN<COLUMNS. Pixel is updated at that rising edge.
  - Otherwise the write is dropped and WRITE_ERROR=1 for exactly the next cycle. This covers out-of-range addresses and any write while BUSY=1.
- Read port:
  - Independent of the write port; latency 1. OUT_DATA at cycle n+1 = pixel addressed at edge n.
  - Same-address read and write in one cycle: OUT_DATA returns the old value (read-first).
  - READ_ROW>=ROWS or READ_COLUMN>=COLUMNS: OUT_DATA=0.
  - Reads are allowed while BUSY=1 and return the current mix of old and fill data.
- Clear FSM, states IDLE and FILL:
  - IDLE + CLEAR=1: latch CLEAR_DATA, zero the counters, go to FILL. BUSY=1 from the next cycle.
  - FILL, each cycle: write the latched colour at (local row r, column c) in all NB banks simultaneously. Then c++. When c=COLUMNS-1, c wraps to 0 and r++.
  - FILL exit: after writing (BANK_ROWS-1, COLUMNS-1), go to IDLE. BUSY=0 the following cycle.
  - Total FILL duration: BANK_ROWS*COLUMNS cycles (20480 at defaults). Rows beyond ROWS in the last bank are also written (harmless).
  - CLEAR while in FILL is ignored, and the colour is not re-latched.
- Simultaneous CLEAR and an accepted WRITE in IDLE: the write happens that cycle; the fill then overwrites it.
- Counters are wide enough to hold COLUMNS-1 and BANK_ROWS-1 without overflow. No arithmetic wrap other than the column wrap above.

Test Plan:
- Reset then write (ROW=100, COLUMN=200, IN_DATA=4'hA). Next cycle read (100,200) -> OUT_DATA=4'hA one cycle after the read address; WRITE_ERROR stays 0.
- Bank boundary: write 4'h3 at (31,0) and 4'h5 at (32,0), then read both -> 4'h3 and 4'h5. Read (479,639) after writing 4'hF there -> 4'hF.
- Out of range: WRITE at (480,0) and at (0,640) -> WRITE_ERROR pulses 1 cycle each, memory unchanged. Read (480,0) -> OUT_DATA=0.
- Clear: CLEAR=1, CLEAR_DATA=4'h7 -> BUSY=1 for exactly 20480 cycles. Afterwards reads of (0,0), (255,317) and (479,639) all return 4'h7. A WRITE issued mid-fill -> WRITE_ERROR=1 and the pixel holds 4'h7.
- Read-first collision: (10,10) holds 4'h1; write 4'h2 and read (10,10) in the same cycle -> OUT_DATA=4'h1. Re-read next cycle -> 4'h2.
- Reset mid-clear: RST after 1000 FILL cycles -> BUSY=0 next cycle. (0,0) reads the fill colour; a never-filled pixel (e.g. (31,639), previously 4'h9) reads 4'h9.
